// File: rtl/fpu_pkg.sv
// Shared types for the FPU request scheduler: opcode enum, op count and FSM state.
package fpu_pkg;

  typedef enum logic [3:0] {
    FADD  = 4'd0,
    FSUB  = 4'd1,
    FMUL  = 4'd2,
    FDIV  = 4'd3,
    FSQRT = 4'd4,
    FTOI  = 4'd5,
    FEQ   = 4'd6,
    FLT   = 4'd7,
    FLE   = 4'd8,
    ITOF  = 4'd9
  } fpu_op_t;

  localparam int unsigned FPU_NUM_OPS = 10;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } fpu_sched_state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return op < 4'(FPU_NUM_OPS);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req_valid;
    if (&req_valid) begin
      grant = ~last_grant;
    end else begin
      grant = ~req_valid[0];
    end
  end

endmodule

// File: rtl/fpu_sched.sv
// Shares one FPU between two requesters: round-robin accept, issue, wait, respond.
// Optional FPU_TIMEOUT_EN adds a watchdog that aborts WAIT after TIMEOUT cycles.
module fpu_sched
  import fpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][3:0]  req_op,
  input  logic [1:0]       req_mode,
  input  logic [1:0][31:0] req_a,
  input  logic [1:0][31:0] req_b,
  output logic [1:0]       rsp_valid,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [3:0]       fpu_control,
  output logic             fpu_mode,
  output logic             fpu_go,
  input  logic [31:0]      fpu_c,
  input  logic             fpu_valid
);

  fpu_sched_state_t state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        mode_q, mode_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;

  logic grant;
  logic grant_valid;

  rr_arb2 u_arb (
    .req_valid   (req_valid),
    .last_grant  (last_grant_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

`ifdef FPU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      ctrl_q       <= '0;
      mode_q       <= 1'b0;
      result_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ctrl_q       <= ctrl_d;
      mode_q       <= mode_d;
      result_q     <= result_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    ctrl_d       = ctrl_q;
    mode_d       = mode_q;
    result_d     = result_q;
    err_d        = err_q;
`ifdef FPU_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          owner_d = grant;
          a_d     = req_a[grant];
          b_d     = req_b[grant];
          ctrl_d  = req_op[grant];
          mode_d  = req_mode[grant];
          if (op_legal(req_op[grant])) begin
            state_d = StIssue;
          end else begin
            // Illegal opcodes are answered without ever starting the FPU.
            result_d = '0;
            err_d    = 1'b1;
            state_d  = StDone;
          end
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef FPU_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        if (fpu_valid) begin
          result_d = fpu_c;
          err_d    = 1'b0;
          state_d  = StDone;
`ifdef FPU_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StDone: begin
        last_grant_d = owner_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = '0;
    // Gated by reset so the accept strobe is low while reset is held.
    if (state_q == StIdle && grant_valid && !reset) begin
      req_ready[grant] = 1'b1;
    end
    rsp_valid = '0;
    if (state_q == StDone) begin
      rsp_valid[owner_q] = 1'b1;
    end
    fpu_go      = (state_q == StIssue);
    rsp_data    = result_q;
    rsp_err     = err_q;
    fpu_a       = a_q;
    fpu_b       = b_q;
    fpu_control = ctrl_q;
    fpu_mode    = mode_q;
  end

endmodule

// File: doc/fpu_sched.md
# fpu_sched

Two-requester scheduler that shares the single FPU datapath between the integer pipeline (requester 0) and the load/store/convert path (requester 1). It arbitrates round-robin, latches the winning operands and opcode, issues a one-cycle go to the FPU, waits for the FPU's valid, and returns the result to the winner. One operation is in flight at a time. The block sits between the core's execute stage and the FPU top level.

## Interface
- TIMEOUT, 64, max cycles waited for fpu_valid after go; used only when the watchdog is compiled in
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  2  per-requester request
- req_ready  out  2  per-requester accept, at most one bit high
- req_op  in  2x4  opcode per requester: 0 fadd … 9 itof
- req_mode  in  2  ftoi rounding mode per requester
- req_a, req_b  in  2x32  operands per requester
- rsp_valid  out  2  one-cycle response strobe to the owning requester
- rsp_data  out  32  result, shared by both requesters
- rsp_err  out  1  qualifies rsp_valid: illegal opcode or timeout
- fpu_a, fpu_b  out  32  operands to the FPU
- fpu_control  out  4  FPU result/valid select
- fpu_mode  out  1  ftoi mode
- fpu_go  out  1  one-cycle start pulse
- fpu_c  in  32  FPU result
- fpu_valid  in  1  FPU result valid

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: grant = round-robin over req_valid. If both requesters are valid, grant the one not granted last. last_grant resets to 1, so requester 0 wins first. req_ready[grant] = req_valid[grant] in IDLE only; it is combinational from state and req_valid. On handshake, latch op/mode/a/b and owner.
  - Opcode ≤ 9: go to ISSUE.
  - Opcode ≥ 10: go directly to DONE with rsp_data = 0 and rsp_err = 1. The FPU is never started.
- ISSUE: fpu_go = 1 for exactly this cycle, then WAIT.
- WAIT: when fpu_valid = 1, capture fpu_c into the result register, then DONE.
- DONE: rsp_valid[owner] = 1 for one cycle, rsp_data and rsp_err valid, then IDLE. Update last_grant to owner.
- fpu_a, fpu_b, fpu_control and fpu_mode come from registers. They hold from the cycle after the handshake until the next accepted request, so they are stable through WAIT.
- fpu_valid is ignored outside WAIT, including stale valid from the previous op.
- rsp_data holds its last value after DONE. Consumers qualify it with rsp_valid only.

## Timing
- Reset values: req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, fpu_go = 0, fpu_a = fpu_b = 0, fpu_control = 0, fpu_mode = 0, state IDLE, last_grant = 1.
- Handshake in cycle N: fpu_go in N+1. WAIT starts at N+2. fpu_valid in cycle V ≥ N+2 gives rsp_valid in V+1. The next handshake is possible in V+2.
- Minimum latency from request to response is 3 cycles (valid at N+2, response at N+3). Minimum issue interval is 4 cycles.
- Illegal opcode: handshake N, response at N+1.
- Reset asserted mid-operation:
  - Immediately returns to IDLE and all outputs go to their reset values.
  - No response is produced for the in-flight op.
  - A late fpu_valid after reset is ignored.
- A request that stays high while the other requester is being served waits. The round-robin rule guarantees it is granted next.

## Configuration
- FPU_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT, width $clog2(TIMEOUT+1), cleared on entry to WAIT.
  - If the counter reaches TIMEOUT without fpu_valid, go to DONE with rsp_data = 0 and rsp_err = 1.
  - fpu_valid arriving in the same cycle the counter reaches TIMEOUT wins: normal result, rsp_err = 0.
- FPU_TIMEOUT_EN undefined: there is no counter, WAIT waits indefinitely, and rsp_err is set only for illegal opcodes.

## Structure
- Package fpu_pkg holds:
  - fpu_op_t enum: FADD = 0, FSUB, FMUL, FDIV, FSQRT, FTOI, FEQ, FLT, FLE, ITOF = 9.
  - FPU_NUM_OPS = 10.
  - fpu_sched_state_t.
- One sub-module, rr_arb2: a 2-way round-robin grant from req_valid and last_grant. It is purely combinational.

## Test plan
- Requester 0 issues fadd, 0x3F800000 + 0x40000000. The FPU model asserts valid 2 cycles after go. Expect: fpu_go for exactly one cycle at N+1; rsp_valid = 2'b01 at N+4; rsp_data = 0x40400000; rsp_err = 0.
- Both requesters valid continuously from reset, with fmul and fdiv. Expect grants alternate 0, 1, 0, 1, and each rsp_valid bit goes only to the owner.
- Requester 1 sends op = 12. Expect: no fpu_go; rsp_valid = 2'b10 one cycle after the handshake; rsp_data = 0; rsp_err = 1.
- fpu_valid pulsed while in IDLE and ISSUE, with the real valid 5 cycles after go. Expect exactly one response, carrying the fpu_c value sampled in WAIT.
- Reset asserted during WAIT, then the FPU asserts valid. Expect no rsp_valid, all outputs at reset values, and the next request served normally.
- With FPU_TIMEOUT_EN and TIMEOUT = 8, the FPU never asserts valid. Expect rsp_err = 1 and rsp_data = 0 at go + 10 cycles. A second run with valid exactly at the timeout cycle returns a normal result with rsp_err = 0.
